store_lane_unit: RTL and testbench
==================================

// Module: store_lane_unit
// PURPOSE
//  Parametrised memory-lane unit between the EX/MEM stage and the data-memory bus.
//  Accepts one load/store request per handshake and emits byte enables, lane-shifted store data and an aligned bus address.
//  Splits word-crossing accesses into two bus beats, or flags them as errors.
//  Supports 32- or 64-bit data buses, with byte/half/word and, on 64-bit buses, dword sizes.
// PARAMETERS
//  DW              32  bus data width; 32 or 64
//  AW              32  address width
//  MISALIGN_SPLIT  1   1: word-crossing access becomes 2 beats; 0: crossing access raises err
// PORTS
//  clk          in   1       clock, rising edge
//  rst_n        in   1       asynchronous active-low reset
//  req_valid    in   1       request valid
//  req_ready    out  1       unit can accept a request (high only in IDLE)
//  req_we       in   1       1=store, 0=load
//  req_size     in   2       00 byte, 01 half, 10 word, 11 dword (legal only if DW=64)
//  req_addr     in   AW      byte address
//  req_wdata    in   DW      store data, right-justified (LSB lanes)
//  bus_valid    out  1       bus beat valid
//  bus_ready    in   1       bus accepts beat
//  bus_we       out  1       write strobe for this beat
//  bus_addr     out  AW      address aligned to NB=DW/8 bytes
//  bus_be       out  DW/8    byte enables; bit i = byte lane i
//  bus_wdata    out  DW      lane-aligned store data; 0 for loads
//  bus_last     out  1       final beat of the request
//  err          out  1       one-cycle pulse: illegal size or forbidden crossing
//  busy         out  1       state != IDLE
// BEHAVIOUR
//  Definitions:
//  - NB=DW/8; LB=log2(NB); off=req_addr[LB-1:0]; n=1<<req_size.
//  - m2 (2*NB bits) = ((1<<n)-1) << off.
//  - d2 (2*DW bits) = (req_wdata masked to n bytes) << (8*off).
//  - cross = (off+n > NB).
//  FSM states: IDLE, BEAT0, BEAT1.
//  IDLE:
//  - req_ready=1; accept on req_valid.
//  - Illegal size (11 with DW=32): err pulses next cycle; no beat; stay IDLE.
//  - cross && !MISALIGN_SPLIT: same as illegal size (err pulse, no beat, stay IDLE).
//  - Otherwise capture request -> BEAT0.
//  BEAT0:
//  - bus_valid=1; bus_addr = addr & ~(NB-1).
//  - bus_be = m2[NB-1:0]; bus_wdata = d2[DW-1:0]; bus_last = !cross.
//  - On bus_ready: go to BEAT1 if cross, else IDLE.
//  BEAT1:
//  - bus_addr = aligned addr + NB (wraps mod 2^AW).
//  - bus_be = m2[2NB-1:NB]; bus_wdata = d2[2DW-1:DW]; bus_last=1.
//  - On bus_ready: IDLE.
//  Timing and handshake:
//  - Latency: request accepted in cycle N -> bus_valid in cycle N+1.
//  - No new request while busy; back-to-back requests give a 1-cycle IDLE bubble.
//  - All bus_* outputs are registered and held stable while bus_valid && !bus_ready.
//  - Loads: bus_we=0, bus_wdata=0, be computed identically (lane select for the load extender).
//  Reset:
//  - rst_n low: state=IDLE; bus_valid, bus_we, bus_be, bus_wdata, bus_addr, bus_last, err, busy all 0.
//  - Reset asserted mid-beat abandons the request immediately; no partial completion.
// TESTING (DW=32 unless noted)
//  - sb addr 0x1003 data 0xAB -> 1 beat: addr 0x1000, be 1000, wdata 0xAB000000, last=1.
//  - sw addr 0x1002 data 0x11223344, split=1:
//      beat0 addr 0x1000 be 1100 wdata 0x33440000 last=0;
//      beat1 addr 0x1004 be 0011 wdata 0x00001122 last=1.
//  - sh addr 0x1001 -> single beat, be 0110; sw addr 0x1001 with split=0 -> err pulse, bus_valid never high.
//  - bus_ready low 3 cycles during BEAT0 -> all bus_* stable; req_ready=0 throughout.
//  - sw addr 0xFFFFFFFE -> beat1 addr 0x00000000 be 0011; rst_n low during BEAT1 -> all outputs 0 that cycle.
//  - DW=64: sd addr 0x10 -> be 0xFF; size=11 with DW=32 -> err pulse, no beat.

Source files
------------

// File: rtl/store_lane_unit_if.sv
// rtl/store_lane_unit_if.sv - request and data-bus signal bundle for the memory-lane unit
interface store_lane_unit_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic [AW-1:0]     req_addr;
    logic [DW-1:0]     req_wdata;

    logic              bus_valid;
    logic              bus_ready;
    logic              bus_we;
    logic [AW-1:0]     bus_addr;
    logic [DW/8-1:0]   bus_be;
    logic [DW-1:0]     bus_wdata;
    logic              bus_last;

    logic              err;
    logic              busy;

    // Unit side: consumes requests, drives the data bus.
    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata, bus_ready,
        output req_ready, bus_valid, bus_we, bus_addr, bus_be, bus_wdata, bus_last,
               err, busy
    );

    // Pipeline/memory side: issues requests, accepts bus beats.
    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata, bus_ready,
        input  req_ready, bus_valid, bus_we, bus_addr, bus_be, bus_wdata, bus_last,
               err, busy
    );
endinterface

// File: rtl/store_lane_unit.sv
// rtl/store_lane_unit.sv - load/store lane unit: byte enables, lane shift, beat split
module store_lane_unit #(
    parameter int DW             = 32,
    parameter int AW             = 32,
    parameter bit MISALIGN_SPLIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    store_lane_unit_if.slave lane
);
    localparam int NB = DW / 8;
    localparam int LB = $clog2(NB);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

    state_t stateQ, stateD;

    // Registered bus outputs plus the upper half of a split access.
    logic          busValidQ, busValidD;
    logic          busWeQ, busWeD;
    logic [AW-1:0] busAddrQ, busAddrD;
    logic [NB-1:0] busBeQ, busBeD;
    logic [DW-1:0] busWdataQ, busWdataD;
    logic          busLastQ, busLastD;
    logic          errQ, errD;
    logic [NB-1:0] beHiQ, beHiD;
    logic [DW-1:0] wdataHiQ, wdataHiD;

    // Request decode.
    logic [LB-1:0]   reqOff;
    logic [3:0]      reqBytes;
    logic [NB-1:0]   byteMask;
    logic [DW-1:0]   dataMasked;
    logic [2*NB-1:0] maskWide;
    logic [2*DW-1:0] dataWide;
    logic            crossReq;
    logic            sizeIllegal;
    logic            rejectReq;

    // Lane mask and shifted data across a double-width window; the upper half feeds beat 1.
    always_comb begin
        reqOff      = lane.req_addr[LB-1:0];
        reqBytes    = 4'd1 << lane.req_size;
        byteMask    = NB'((16'd1 << reqBytes) - 16'd1);
        dataMasked  = '0;
        for (int i = 0; i < NB; i++) begin
            dataMasked[8*i +: 8] = (lane.req_we && byteMask[i]) ? lane.req_wdata[8*i +: 8] : 8'h00;
        end
        maskWide    = {{NB{1'b0}}, byteMask} << reqOff;
        dataWide    = {{DW{1'b0}}, dataMasked} << {reqOff, 3'b000};
        crossReq    = (5'(reqOff) + 5'(reqBytes)) > 5'(NB);
        sizeIllegal = (lane.req_size == 2'b11) && (DW == 32);
        rejectReq   = sizeIllegal || (crossReq && !MISALIGN_SPLIT);
    end

    // Next-state and next bus values; every completed request clears the bus back to zero.
    always_comb begin
        stateD    = stateQ;
        busValidD = busValidQ;
        busWeD    = busWeQ;
        busAddrD  = busAddrQ;
        busBeD    = busBeQ;
        busWdataD = busWdataQ;
        busLastD  = busLastQ;
        beHiD     = beHiQ;
        wdataHiD  = wdataHiQ;
        errD      = 1'b0;
        case (stateQ)
            IDLE: begin
                if (lane.req_valid) begin
                    if (rejectReq) begin
                        errD = 1'b1;
                    end else begin
                        stateD    = BEAT0;
                        busValidD = 1'b1;
                        busWeD    = lane.req_we;
                        busAddrD  = lane.req_addr & ~AW'(NB - 1);
                        busBeD    = maskWide[NB-1:0];
                        busWdataD = dataWide[DW-1:0];
                        busLastD  = !crossReq;
                        beHiD     = maskWide[2*NB-1:NB];
                        wdataHiD  = dataWide[2*DW-1:DW];
                    end
                end
            end
            BEAT0: begin
                if (lane.bus_ready) begin
                    if (!busLastQ) begin
                        stateD    = BEAT1;
                        busAddrD  = busAddrQ + AW'(NB);
                        busBeD    = beHiQ;
                        busWdataD = wdataHiQ;
                        busLastD  = 1'b1;
                    end else begin
                        stateD    = IDLE;
                        busValidD = 1'b0;
                        busWeD    = 1'b0;
                        busAddrD  = '0;
                        busBeD    = '0;
                        busWdataD = '0;
                        busLastD  = 1'b0;
                    end
                end
            end
            BEAT1: begin
                if (lane.bus_ready) begin
                    stateD    = IDLE;
                    busValidD = 1'b0;
                    busWeD    = 1'b0;
                    busAddrD  = '0;
                    busBeD    = '0;
                    busWdataD = '0;
                    busLastD  = 1'b0;
                end
            end
            default: begin
                stateD    = IDLE;
                busValidD = 1'b0;
            end
        endcase
    end

    // State register; reset abandons any beat in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    // Bus output and split-half registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busValidQ <= 1'b0;
            busWeQ    <= 1'b0;
            busAddrQ  <= '0;
            busBeQ    <= '0;
            busWdataQ <= '0;
            busLastQ  <= 1'b0;
            errQ      <= 1'b0;
            beHiQ     <= '0;
            wdataHiQ  <= '0;
        end else begin
            busValidQ <= busValidD;
            busWeQ    <= busWeD;
            busAddrQ  <= busAddrD;
            busBeQ    <= busBeD;
            busWdataQ <= busWdataD;
            busLastQ  <= busLastD;
            errQ      <= errD;
            beHiQ     <= beHiD;
            wdataHiQ  <= wdataHiD;
        end
    end

    assign lane.req_ready = (stateQ == IDLE);
    assign lane.busy      = (stateQ != IDLE);
    assign lane.bus_valid = busValidQ;
    assign lane.bus_we    = busWeQ;
    assign lane.bus_addr  = busAddrQ;
    assign lane.bus_be    = busBeQ;
    assign lane.bus_wdata = busWdataQ;
    assign lane.bus_last  = busLastQ;
    assign lane.err       = errQ;
endmodule

// File: tb/tb_store_lane_unit.sv
// tb/tb_store_lane_unit.sv - self-checking bench for store_lane_unit
module tb_store_lane_unit;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    store_lane_unit_if #(.DW(32), .AW(32)) ifA ();
    store_lane_unit_if #(.DW(32), .AW(32)) ifB ();
    store_lane_unit_if #(.DW(64), .AW(32)) ifC ();

    store_lane_unit #(.DW(32), .AW(32), .MISALIGN_SPLIT(1'b1)) dutA (.clk(clk), .rst_n(rst_n), .lane(ifA));
    store_lane_unit #(.DW(32), .AW(32), .MISALIGN_SPLIT(1'b0)) dutB (.clk(clk), .rst_n(rst_n), .lane(ifB));
    store_lane_unit #(.DW(64), .AW(32), .MISALIGN_SPLIT(1'b1)) dutC (.clk(clk), .rst_n(rst_n), .lane(ifC));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        expErr;
        logic        twoBeats;
        logic [31:0] a0;
        logic [3:0]  be0;
        logic [31:0] d0;
        logic [31:0] a1;
        logic [3:0]  be1;
        logic [31:0] d1;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic runVector(input int i);
        vec_t v;
        v = vecs[i];
        @(negedge clk);
        check($sformatf("v%0d_req_ready", i), 64'(ifA.req_ready), 64'd1);
        ifA.req_valid = 1'b1;
        ifA.req_we    = v.we;
        ifA.req_size  = v.size;
        ifA.req_addr  = v.addr;
        ifA.req_wdata = v.wdata;
        @(negedge clk);
        ifA.req_valid = 1'b0;
        if (v.expErr) begin
            check($sformatf("v%0d_err", i), 64'(ifA.err), 64'd1);
            check($sformatf("v%0d_err_valid", i), 64'(ifA.bus_valid), 64'd0);
        end else begin
            check($sformatf("v%0d_valid0", i), 64'(ifA.bus_valid), 64'd1);
            check($sformatf("v%0d_we0", i), 64'(ifA.bus_we), 64'(v.we));
            check($sformatf("v%0d_addr0", i), 64'(ifA.bus_addr), 64'(v.a0));
            check($sformatf("v%0d_be0", i), 64'(ifA.bus_be), 64'(v.be0));
            check($sformatf("v%0d_wdata0", i), 64'(ifA.bus_wdata), 64'(v.d0));
            check($sformatf("v%0d_last0", i), 64'(ifA.bus_last), 64'(!v.twoBeats));
            if (v.twoBeats) begin
                @(negedge clk);
                check($sformatf("v%0d_valid1", i), 64'(ifA.bus_valid), 64'd1);
                check($sformatf("v%0d_addr1", i), 64'(ifA.bus_addr), 64'(v.a1));
                check($sformatf("v%0d_be1", i), 64'(ifA.bus_be), 64'(v.be1));
                check($sformatf("v%0d_wdata1", i), 64'(ifA.bus_wdata), 64'(v.d1));
                check($sformatf("v%0d_last1", i), 64'(ifA.bus_last), 64'd1);
            end
        end
        @(negedge clk);
        check($sformatf("v%0d_idle_valid", i), 64'(ifA.bus_valid), 64'd0);
        check($sformatf("v%0d_idle_busy", i), 64'(ifA.busy), 64'd0);
        check($sformatf("v%0d_idle_err", i), 64'(ifA.err), 64'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        //          we    size  addr           wdata          err   two   a0             be0    d0             a1             be1    d1
        vecs[0] = '{1'b1, 2'd0, 32'h0000_1003, 32'h0000_00AB, 1'b0, 1'b0, 32'h0000_1000, 4'h8, 32'hAB00_0000, 32'h0,         4'h0, 32'h0};
        vecs[1] = '{1'b1, 2'd2, 32'h0000_1002, 32'h1122_3344, 1'b0, 1'b1, 32'h0000_1000, 4'hC, 32'h3344_0000, 32'h0000_1004, 4'h3, 32'h0000_1122};
        vecs[2] = '{1'b1, 2'd1, 32'h0000_1001, 32'h0000_BEEF, 1'b0, 1'b0, 32'h0000_1000, 4'h6, 32'h00BE_EF00, 32'h0,         4'h0, 32'h0};
        vecs[3] = '{1'b1, 2'd2, 32'h0000_2000, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0000_2000, 4'hF, 32'hDEAD_BEEF, 32'h0,         4'h0, 32'h0};
        vecs[4] = '{1'b0, 2'd2, 32'h0000_2003, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0000_2000, 4'h8, 32'h0,         32'h0000_2004, 4'h7, 32'h0};
        vecs[5] = '{1'b1, 2'd1, 32'h0000_1003, 32'hFFFF_1234, 1'b0, 1'b1, 32'h0000_1000, 4'h8, 32'h3400_0000, 32'h0000_1004, 4'h1, 32'h0000_0012};
        vecs[6] = '{1'b1, 2'd0, 32'h0000_1000, 32'hFFFF_FF5A, 1'b0, 1'b0, 32'h0000_1000, 4'h1, 32'h0000_005A, 32'h0,         4'h0, 32'h0};
        vecs[7] = '{1'b1, 2'd3, 32'h0000_1000, 32'h1234_5678, 1'b1, 1'b0, 32'h0,         4'h0, 32'h0,         32'h0,         4'h0, 32'h0};
        vecs[8] = '{1'b0, 2'd1, 32'h0000_1002, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_1000, 4'hC, 32'h0,         32'h0,         4'h0, 32'h0};
        vecs[9] = '{1'b1, 2'd2, 32'hFFFF_FFFE, 32'hAABB_CCDD, 1'b0, 1'b1, 32'hFFFF_FFFC, 4'hC, 32'hCCDD_0000, 32'h0000_0000, 4'h3, 32'h0000_AABB};

        rst_n = 1'b0;
        ifA.req_valid = 1'b0; ifA.req_we = 1'b0; ifA.req_size = 2'd0; ifA.req_addr = '0; ifA.req_wdata = '0; ifA.bus_ready = 1'b1;
        ifB.req_valid = 1'b0; ifB.req_we = 1'b0; ifB.req_size = 2'd0; ifB.req_addr = '0; ifB.req_wdata = '0; ifB.bus_ready = 1'b1;
        ifC.req_valid = 1'b0; ifC.req_we = 1'b0; ifC.req_size = 2'd0; ifC.req_addr = '0; ifC.req_wdata = '0; ifC.bus_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(ifA.bus_valid), 64'd0);
        check("rst_busy", 64'(ifA.busy), 64'd0);
        check("rst_err", 64'(ifA.err), 64'd0);
        check("rst_be", 64'(ifA.bus_be), 64'd0);
        check("rst_last", 64'(ifA.bus_last), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            runVector(i);
        end

        // Stall in BEAT0 for three cycles: outputs frozen, no new request accepted
        @(negedge clk);
        ifA.bus_ready = 1'b0;
        ifA.req_valid = 1'b1; ifA.req_we = 1'b1; ifA.req_size = 2'd2;
        ifA.req_addr = 32'h0000_1002; ifA.req_wdata = 32'h1122_3344;
        @(negedge clk);
        ifA.req_addr = 32'h0000_3000;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("stall%0d_valid", c), 64'(ifA.bus_valid), 64'd1);
            check($sformatf("stall%0d_addr", c), 64'(ifA.bus_addr), 64'h1000);
            check($sformatf("stall%0d_be", c), 64'(ifA.bus_be), 64'hC);
            check($sformatf("stall%0d_wdata", c), 64'(ifA.bus_wdata), 64'h3344_0000);
            check($sformatf("stall%0d_last", c), 64'(ifA.bus_last), 64'd0);
            check($sformatf("stall%0d_req_ready", c), 64'(ifA.req_ready), 64'd0);
            @(negedge clk);
        end
        ifA.req_valid = 1'b0;
        ifA.bus_ready = 1'b1;
        @(negedge clk);
        check("stall_beat1_addr", 64'(ifA.bus_addr), 64'h1004);
        check("stall_beat1_be", 64'(ifA.bus_be), 64'h3);
        check("stall_beat1_req_ready", 64'(ifA.req_ready), 64'd0);
        @(negedge clk);
        check("stall_done_valid", 64'(ifA.bus_valid), 64'd0);

        // Wrap across the top of the address space, then reset while BEAT1 is held
        @(negedge clk);
        ifA.req_valid = 1'b1; ifA.req_we = 1'b1; ifA.req_size = 2'd2;
        ifA.req_addr = 32'hFFFF_FFFE; ifA.req_wdata = 32'hAABB_CCDD;
        @(negedge clk);
        ifA.req_valid = 1'b0;
        check("wrap_beat0_addr", 64'(ifA.bus_addr), 64'hFFFF_FFFC);
        @(negedge clk);
        ifA.bus_ready = 1'b0;
        check("wrap_beat1_addr", 64'(ifA.bus_addr), 64'h0);
        check("wrap_beat1_be", 64'(ifA.bus_be), 64'h3);
        check("wrap_beat1_valid", 64'(ifA.bus_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(ifA.bus_valid), 64'd0);
        check("midrst_we", 64'(ifA.bus_we), 64'd0);
        check("midrst_be", 64'(ifA.bus_be), 64'd0);
        check("midrst_wdata", 64'(ifA.bus_wdata), 64'd0);
        check("midrst_addr", 64'(ifA.bus_addr), 64'd0);
        check("midrst_last", 64'(ifA.bus_last), 64'd0);
        check("midrst_busy", 64'(ifA.busy), 64'd0);
        check("midrst_err", 64'(ifA.err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ifA.bus_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("postrst_valid", 64'(ifA.bus_valid), 64'd0);
        check("postrst_ready", 64'(ifA.req_ready), 64'd1);

        // Split disabled: crossing word raises err, never a beat
        @(negedge clk);
        ifB.req_valid = 1'b1; ifB.req_we = 1'b1; ifB.req_size = 2'd2;
        ifB.req_addr = 32'h0000_1001; ifB.req_wdata = 32'h1122_3344;
        @(negedge clk);
        ifB.req_valid = 1'b0;
        check("nosplit_err", 64'(ifB.err), 64'd1);
        check("nosplit_valid", 64'(ifB.bus_valid), 64'd0);
        check("nosplit_busy", 64'(ifB.busy), 64'd0);
        @(negedge clk);
        check("nosplit_err_pulse", 64'(ifB.err), 64'd0);
        check("nosplit_valid_after", 64'(ifB.bus_valid), 64'd0);
        ifB.req_valid = 1'b1; ifB.req_size = 2'd1;
        @(negedge clk);
        ifB.req_valid = 1'b0;
        check("nosplit_sh_valid", 64'(ifB.bus_valid), 64'd1);
        check("nosplit_sh_be", 64'(ifB.bus_be), 64'h6);
        check("nosplit_sh_last", 64'(ifB.bus_last), 64'd1);
        check("nosplit_sh_err", 64'(ifB.err), 64'd0);
        @(negedge clk);

        // 64-bit bus: aligned dword, then a crossing word
        ifC.req_valid = 1'b1; ifC.req_we = 1'b1; ifC.req_size = 2'd3;
        ifC.req_addr = 32'h0000_0010; ifC.req_wdata = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        ifC.req_valid = 1'b0;
        check("dw64_sd_valid", 64'(ifC.bus_valid), 64'd1);
        check("dw64_sd_be", 64'(ifC.bus_be), 64'hFF);
        check("dw64_sd_wdata", ifC.bus_wdata, 64'h0123_4567_89AB_CDEF);
        check("dw64_sd_addr", 64'(ifC.bus_addr), 64'h10);
        check("dw64_sd_last", 64'(ifC.bus_last), 64'd1);
        check("dw64_sd_err", 64'(ifC.err), 64'd0);
        @(negedge clk);
        ifC.req_valid = 1'b1; ifC.req_size = 2'd2;
        ifC.req_addr = 32'h0000_0016; ifC.req_wdata = 64'h0000_0000_A1B2_C3D4;
        @(negedge clk);
        ifC.req_valid = 1'b0;
        check("dw64_sw_be0", 64'(ifC.bus_be), 64'hC0);
        check("dw64_sw_wdata0", ifC.bus_wdata, 64'hC3D4_0000_0000_0000);
        check("dw64_sw_addr0", 64'(ifC.bus_addr), 64'h10);
        check("dw64_sw_last0", 64'(ifC.bus_last), 64'd0);
        @(negedge clk);
        check("dw64_sw_be1", 64'(ifC.bus_be), 64'h03);
        check("dw64_sw_wdata1", ifC.bus_wdata, 64'h0000_0000_0000_A1B2);
        check("dw64_sw_addr1", 64'(ifC.bus_addr), 64'h18);
        check("dw64_sw_last1", 64'(ifC.bus_last), 64'd1);
        @(negedge clk);
        check("dw64_idle", 64'(ifC.busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
